// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of pending core stores, drained one per cycle into a single-port data RAM.
// Optional feature macro STORE_BUF_FWD_EN: full-word youngest hits are forwarded to loads without stalling.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              core_we,
  input  logic                    core_re,
  input  logic [31:0]             core_addr,
  input  logic [31:0]             core_wdata,
  output logic [31:0]             core_rdata,
  output logic                    stall,
  output logic [3:0]              mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic [PW-1:0] head, tail;
  logic is_st, is_ld, full, hit, owns, drain, push, fwd;
`ifdef STORE_BUF_FWD_EN
  logic [3:0]  yng_we;
  logic [31:0] yng_data;
`endif

  assign is_st = |core_we;
  assign is_ld = core_re & ~is_st;   // a store wins over a simultaneous load
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Walk oldest to youngest so the last match left standing is the youngest hit.
  always_comb begin
    hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
    yng_we   = 4'h0;
    yng_data = 32'h0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (ent[head + PW'(k)].waddr == core_addr[31:2])) begin
        hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        yng_we   = ent[head + PW'(k)].we;
        yng_data = ent[head + PW'(k)].wdata;
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign fwd = is_ld & hit & (yng_we == 4'hF);
`else
  assign fwd = 1'b0;
`endif

  assign owns  = is_ld & ~hit;
  assign drain = ~owns & ~empty;
  assign push  = is_st & ~full;
  assign stall = (is_st & full) | (is_ld & hit & ~fwd);

  assign mem_we    = drain ? ent[head].we : 4'h0;
  assign mem_addr  = drain ? {ent[head].waddr, 2'b00} : core_addr;
  assign mem_wdata = drain ? ent[head].wdata : 32'h0;

  always_comb begin
    core_rdata = 32'h0;
    if (owns) core_rdata = mem_rdata;
`ifdef STORE_BUF_FWD_EN
    else if (fwd) core_rdata = yng_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ent[tail] <= '{waddr: core_addr[31:2], we: core_we, wdata: core_wdata};
        tail      <= tail + PW'(1);
      end
      if (drain) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(drain);
      assert (!(core_re && is_st)) else $error("store_buffer: load and store requested together");
    end
  end
endmodule
